// File: rtl/red_pkg.sv
// Shared definitions for the RED reduction path: FSM state encoding and
// lane/accumulator sizing helpers.
package red_pkg;

  typedef enum logic [1:0] {
    RED_IDLE  = 2'd0,
    RED_ACCUM = 2'd1,
    RED_DONE  = 2'd2
  } red_state_e;

  function automatic int red_clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Room for 2*n_lanes lane values plus a sign bit, so the running sum never wraps.
  function automatic int red_acc_w(input int lane_w, input int n_lanes);
    return lane_w + red_clog2(2 * n_lanes) + 1;
  endfunction

endpackage

// File: rtl/red_lane_adder.sv
// One reduction step: extend two lanes to accumulator width and add them
// to the running sum.
module red_lane_adder #(
  parameter int LANE_W = 4,
  parameter int ACC_W  = 8
) (
  input  logic [LANE_W-1:0] i_lane_a,
  input  logic [LANE_W-1:0] i_lane_b,
  input  logic              i_signed,
  input  logic [ACC_W-1:0]  i_acc,
  output logic [ACC_W-1:0]  o_acc_nxt
);

  logic [ACC_W-1:0] w_ext_a, w_ext_b;

  assign w_ext_a   = i_signed ? ACC_W'($signed(i_lane_a)) : ACC_W'(i_lane_a);
  assign w_ext_b   = i_signed ? ACC_W'($signed(i_lane_b)) : ACC_W'(i_lane_b);
  assign o_acc_nxt = i_acc + w_ext_a + w_ext_b;

endmodule

// File: rtl/red_reduce_seq.sv
// Sequential lane-sum reduction for RED: accumulates one lane pair of A and B
// per clock, then holds the extended sum until the consumer takes it.
module red_reduce_seq
  import red_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LANE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int N_LANES = WIDTH / LANE_W;
  localparam int ACC_W   = red_acc_w(LANE_W, N_LANES);
  localparam int IDX_W   = red_clog2(N_LANES);

  if (LANE_W < 2 || (WIDTH % LANE_W) != 0 || N_LANES < 2 || ACC_W > WIDTH) begin : g_bad_params
    $error("red_reduce_seq: illegal WIDTH/LANE_W combination");
  end

  red_state_e r_state, w_state_nxt;

  logic [N_LANES-1:0][LANE_W-1:0] r_a, r_b;
  logic                           r_sm;
  logic [ACC_W-1:0]               r_acc, w_acc_nxt;
  logic [IDX_W-1:0]               r_idx;
  logic [WIDTH-1:0]               r_result, w_result_ext;
  logic                           w_accept, w_last;

  assign w_accept     = in_valid && in_ready;
  assign w_last       = (r_idx == IDX_W'(N_LANES - 1));
  assign w_result_ext = r_sm ? WIDTH'($signed(w_acc_nxt)) : WIDTH'(w_acc_nxt);
  assign result       = r_result;

  red_lane_adder #(
    .LANE_W (LANE_W),
    .ACC_W  (ACC_W)
  ) u_lane_add (
    .i_lane_a  (r_a[r_idx]),
    .i_lane_b  (r_b[r_idx]),
    .i_signed  (r_sm),
    .i_acc     (r_acc),
    .o_acc_nxt (w_acc_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      RED_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = RED_ACCUM;
      end
      RED_ACCUM: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = RED_DONE;
      end
      RED_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = RED_IDLE;
      end
      default: w_state_nxt = RED_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RED_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Operands are captured only on acceptance; the bus is ignored while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sm     <= 1'b0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_sm  <= signed_mode;
      r_acc <= '0;
      r_idx <= '0;
    end else if (r_state == RED_ACCUM) begin
      r_acc <= w_acc_nxt;
      if (w_last) r_result <= w_result_ext;
      else        r_idx    <= r_idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_red_reduce_seq.sv
// Bench for red_reduce_seq: a 16/4 instance and a 32/8 instance checked every
// cycle against a lane-sum scoreboard, plus directed literal expectations.
module tb_red_reduce_seq;

  localparam int LAT = 5;  // negedges from the one before the accepting edge to first out_valid

  logic        clk, rst_n;
  logic        iv0, rdy0, ov0, or0, sm0, busy0;
  logic [15:0] a0, b0, res0;
  logic        iv1, rdy1, ov1, or1, sm1, busy1;
  logic [31:0] a1, b1, res1;

  int          n_vec, n_err, cyc;
  bit          pend [2];
  logic [31:0] exp_r [2];
  int          acc_c [2];
  int          hist [8];
  int          n_hist;

  red_reduce_seq #(.WIDTH(16), .LANE_W(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(rdy0), .a(a0), .b(b0),
    .signed_mode(sm0), .out_valid(ov0), .out_ready(or0), .result(res0), .busy(busy0));

  red_reduce_seq #(.WIDTH(32), .LANE_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(rdy1), .a(a1), .b(b1),
    .signed_mode(sm1), .out_valid(ov1), .out_ready(or1), .result(res1), .busy(busy1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sum of every lane of both operands, each lane read as signed or unsigned.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input bit sm, input int w, input int lw);
    longint s, v, m;
    s = 0;
    m = (longint'(1) << lw) - 1;
    for (int i = 0; i < w / lw; i++) begin
      v = (longint'(a) >> (i * lw)) & m;
      if (sm && v > m / 2) v -= m + 1;
      s += v;
      v = (longint'(b) >> (i * lw)) & m;
      if (sm && v > m / 2) v -= m + 1;
      s += v;
    end
    return 32'(s & ((longint'(1) << w) - 1));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic        rdy_of(input int d);  return d ? rdy1 : rdy0;   endfunction
  function automatic logic        ov_of(input int d);   return d ? ov1 : ov0;     endfunction
  function automatic logic        iv_of(input int d);   return d ? iv1 : iv0;     endfunction
  function automatic logic        or_of(input int d);   return d ? or1 : or0;     endfunction
  function automatic logic        bz_of(input int d);   return d ? busy1 : busy0; endfunction
  function automatic logic [31:0] res_of(input int d);  return d ? res1 : {16'h0, res0}; endfunction

  // Scoreboard: at most one operation in flight per instance.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pend[0] = 1'b0;
      pend[1] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("dut%0d busy", d), 32'(bz_of(d)), 32'(pend[d]));
        chk($sformatf("dut%0d in_ready", d), 32'(rdy_of(d)), 32'(!pend[d]));
        chk($sformatf("dut%0d out_valid", d), 32'(ov_of(d)),
            32'(pend[d] && (cyc - acc_c[d] >= LAT)));
        if (ov_of(d)) chk($sformatf("dut%0d result", d), res_of(d), exp_r[d]);
        if (ov_of(d) && or_of(d)) pend[d] = 1'b0;
        else if (iv_of(d) && rdy_of(d)) begin
          pend[d]  = 1'b1;
          acc_c[d] = cyc;
          exp_r[d] = d ? model(a1, b1, sm1, 32, 8) : model({16'h0, a0}, {16'h0, b0}, sm0, 16, 4);
          if (d == 1 && n_hist < 8) begin
            hist[n_hist] = cyc;
            n_hist++;
          end
        end
      end
    end
  end

  task automatic drive(input int d, input logic [31:0] a, input logic [31:0] b,
                       input bit sm, input bit v);
    if (d == 0) begin a0 = a[15:0]; b0 = b[15:0]; sm0 = sm; iv0 = v; end
    else        begin a1 = a;       b1 = b;       sm1 = sm; iv1 = v; end
  endtask

  // Issue one op, scramble the bus after capture, wait for the result.
  task automatic op(input int d, input logic [31:0] a, input logic [31:0] b, input bit sm,
                    input logic [31:0] lit, input string nm);
    int t;
    drive(d, a, b, sm, 1'b1);
    t = 0;
    while (!rdy_of(d) && t < 50) begin @(posedge clk); #1; t++; end
    chk({nm, " accept"}, 32'(rdy_of(d)), 32'd1);
    @(posedge clk); #1;
    drive(d, ~a, ~b, !sm, 1'b0);
    t = 0;
    while (!ov_of(d) && t < 50) begin @(posedge clk); #1; t++; end
    chk({nm, " valid"}, 32'(ov_of(d)), 32'd1);
    chk({nm, " result"}, res_of(d), lit);
    @(posedge clk); #1;
  endtask

  initial begin
    int t;
    n_vec = 0; n_err = 0; cyc = 0; n_hist = 0;
    rst_n = 1'b1; or0 = 1'b1; or1 = 1'b1;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("reset in_ready0", 32'(rdy0), 32'd1);
    chk("reset out_valid0", 32'(ov0), 32'd0);
    chk("reset busy0", 32'(busy0), 32'd0);
    chk("reset result0", 32'(res0), 32'd0);
    chk("reset in_ready1", 32'(rdy1), 32'd1);
    chk("reset result1", res1, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    op(0, 32'h1111, 32'h1111, 1'b0, 32'h0008, "u ones");
    op(0, 32'hFFFF, 32'hFFFF, 1'b0, 32'h0078, "u max");
    op(0, 32'hFFFF, 32'hFFFF, 1'b1, 32'hFFF8, "s minus1");
    op(0, 32'h8888, 32'h8888, 1'b1, 32'hFFC0, "s min");
    op(0, 32'h7777, 32'h8888, 1'b1, 32'hFFFC, "s mixed");
    op(0, 32'h8888, 32'h8888, 1'b0, 32'h0040, "u eights");
    op(0, 32'h0F0F, 32'hF0F0, 1'b1, 32'hFFFC, "s alt");
    op(0, 32'h7777, 32'h0000, 1'b1, 32'h001C, "s pos");

    or0 = 1'b0;
    op(0, 32'h1234, 32'h4321, 1'b0, 32'h0014, "bp");
    for (int i = 0; i < 5; i++) begin
      drive(0, 32'hFFFF, 32'hFFFF, 1'b1, 1'b1);
      chk("bp held valid", 32'(ov0), 32'd1);
      chk("bp held result", 32'(res0), 32'h0014);
      chk("bp in_ready", 32'(rdy0), 32'd0);
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0);
    or0 = 1'b1;
    @(posedge clk); #1;
    chk("bp released", 32'(ov0), 32'd0);

    drive(0, 32'hFFFF, 32'hFFFF, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid rst out_valid", 32'(ov0), 32'd0);
    chk("mid rst in_ready", 32'(rdy0), 32'd1);
    chk("mid rst busy", 32'(busy0), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) begin
      chk("post rst quiet", 32'(ov0), 32'd0);
      @(posedge clk); #1;
    end
    op(0, 32'h0001, 32'h0002, 1'b0, 32'h0003, "after rst");

    op(1, 32'h7F7F7F7F, 32'h7F7F7F7F, 1'b1, 32'h000003F8, "w32 s max");
    op(1, 32'h80808080, 32'h80808080, 1'b1, 32'hFFFFFC00, "w32 s min");
    op(1, 32'h80808080, 32'h80808080, 1'b0, 32'h00000400, "w32 u");

    n_hist = 0;
    drive(1, 32'h01020304, 32'h10203040, 1'b0, 1'b1);
    t = 0;
    while (n_hist < 3 && t < 100) begin @(posedge clk); #1; t++; end
    drive(1, 0, 0, 0, 0);
    chk("b2b accepts", 32'(n_hist), 32'd3);
    chk("b2b spacing 1", 32'(hist[1] - hist[0]), 32'd6);
    chk("b2b spacing 2", 32'(hist[2] - hist[1]), 32'd6);
    chk("b2b model", model(32'h01020304, 32'h10203040, 1'b0, 32, 8), 32'h000000AA);
    repeat (10) @(posedge clk);
    #1;
    chk("drained", 32'(busy1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
